// File: rtl/adat_pkg.sv
// Shared ADAT frame geometry and the frame reader FSM state encoding.
package adat_pkg;

    localparam int ADAT_CHANNELS = 8;
    localparam int SLOT_BITS     = 32;
    localparam int FRAME_BITS    = ADAT_CHANNELS * SLOT_BITS;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        READ = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/adat_frame_reader_if.sv
// Sample stream leaving the ADAT frame reader.
interface adat_frame_reader_if #(
    parameter int SAMPLE_BITS = 24
);
    // A transfer happens on every clock edge where sample_valid and sample_ready are both high;
    // once sample_valid rises, data/channel/last stay frozen and valid stays high until that edge.
    logic [SAMPLE_BITS-1:0] sample_data;
    logic [2:0]             sample_channel;
    logic                   sample_last;
    logic                   sample_valid;
    logic                   sample_ready;

    modport master (
        output sample_data, sample_channel, sample_last, sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data, sample_channel, sample_last, sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/serial_sample_shifter.sv
// MSB-first serial-to-parallel shifter; each new bit enters at the LSB, clear wipes the word.
module serial_sample_shifter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], bit_in};
        end
    end

endmodule

// File: rtl/adat_frame_reader.sv
// Walks completed frames in the bit-addressed channel buffer and emits one MSB-aligned
// sample per ADAT channel over a valid/ready stream, skipping ahead when the writer laps us.
module adat_frame_reader
    import adat_pkg::*;
#(
    parameter int CIRC_BUF_BITS = 3,
    parameter int SAMPLE_BITS   = 24
) (
    input  logic                     clk_x4_i,
    input  logic                     reset_i,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
    input  logic                     ram_read_data_i,
    output logic [SAMPLE_BITS-1:0]   sample_data_o,
    output logic [2:0]               sample_channel_o,
    output logic                     sample_last_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic                     overrun_o,
    output state_t                   debug_state_o
);

    typedef logic [CIRC_BUF_BITS-1:0] idx_t;

    localparam idx_t       OVR_LIMIT = idx_t'((1 << CIRC_BUF_BITS) - 2);
    localparam logic [2:0] LAST_CH   = 3'(ADAT_CHANNELS - 1);
    localparam logic [4:0] LAST_BIT  = 5'(SAMPLE_BITS - 1);

    state_t     state, state_nx;
    idx_t       rd_idx, sync_ref;
    logic       sync_armed;
    logic [2:0] ch;
    logic [4:0] bit_cnt;
    logic       cap_q;
    logic       shift_clear;
    idx_t       lg_next, backlog;
    logic       frame_pending, overrun_hit, accept;

    assign lg_next       = last_good_frame_idx_i + idx_t'(1);
    assign backlog       = last_good_frame_idx_i - rd_idx;
    assign frame_pending = (rd_idx != lg_next);
    // A caught-up reader also shows the maximum backlog, so only a non-empty buffer counts as lapped.
    assign overrun_hit   = (state == IDLE) && frame_pending && (backlog >= OVR_LIMIT);
    assign accept        = sample_valid_o && sample_ready_i;
    assign debug_state_o = state;

    always_comb begin
        state_nx        = state;
        ram_read_addr_o = '0;
        case (state)
            SYNC: if (sync_armed && (last_good_frame_idx_i != sync_ref)) state_nx = IDLE;
            IDLE: if (!overrun_hit && frame_pending) state_nx = READ;
            READ: begin
                ram_read_addr_o = {rd_idx, ch, bit_cnt};
                if (bit_cnt == LAST_BIT) state_nx = HOLD;
            end
            HOLD: if (accept) state_nx = (ch == LAST_CH) ? IDLE : READ;
            default: state_nx = SYNC;
        endcase
        shift_clear = (state_nx == READ) && (state != READ);
    end

    always_ff @(posedge clk_x4_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= SYNC;
            rd_idx           <= '0;
            sync_ref         <= '0;
            sync_armed       <= 1'b0;
            ch               <= '0;
            bit_cnt          <= '0;
            cap_q            <= 1'b0;
            sample_channel_o <= '0;
            sample_last_o    <= 1'b0;
            sample_valid_o   <= 1'b0;
            overrun_o        <= 1'b0;
        end else begin
            state     <= state_nx;
            cap_q     <= (state == READ);
            overrun_o <= overrun_hit;
            case (state)
                SYNC: begin
                    if (!sync_armed) begin
                        sync_armed <= 1'b1;
                        sync_ref   <= last_good_frame_idx_i;
                    end else if (last_good_frame_idx_i != sync_ref) begin
                        rd_idx <= last_good_frame_idx_i;
                    end
                end
                IDLE: begin
                    ch      <= '0;
                    bit_cnt <= '0;
                    if (overrun_hit) rd_idx <= last_good_frame_idx_i;
                end
                READ: bit_cnt <= bit_cnt + 5'd1;
                HOLD: begin
                    // First HOLD cycle still carries the final data bit from the buffer.
                    if (cap_q) begin
                        sample_valid_o   <= 1'b1;
                        sample_channel_o <= ch;
                        sample_last_o    <= (ch == LAST_CH);
                    end else if (accept) begin
                        sample_valid_o <= 1'b0;
                        bit_cnt        <= '0;
                        if (ch == LAST_CH) begin
                            ch     <= '0;
                            rd_idx <= rd_idx + idx_t'(1);
                        end else begin
                            ch <= ch + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    serial_sample_shifter #(
        .WIDTH (SAMPLE_BITS)
    ) u_shifter (
        .clk      (clk_x4_i),
        .rst      (reset_i),
        .clear    (shift_clear),
        .shift_en (cap_q),
        .bit_in   (ram_read_data_i),
        .data     (sample_data_o)
    );

endmodule

// File: tb/tb_adat_frame_reader.sv
// Randomized bench for adat_frame_reader against a frame-level model of the reading order.
module tb_adat_frame_reader;
    import adat_pkg::*;

    localparam int CB = 3;
    localparam int SB = 24;
    localparam int NF = 1 << CB;
    localparam int AW = CB + 8;
    localparam int EW = CB + 3 + SB;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [CB-1:0] lg;
    logic [AW-1:0] ram_addr;
    logic          ram_rdata;
    logic          overrun;
    state_t        dbg_state;

    adat_frame_reader_if #(.SAMPLE_BITS(SB)) rd_if ();

    adat_frame_reader #(
        .CIRC_BUF_BITS (CB),
        .SAMPLE_BITS   (SB)
    ) dut (
        .clk_x4_i              (clk),
        .reset_i               (reset),
        .last_good_frame_idx_i (lg),
        .ram_read_addr_o       (ram_addr),
        .ram_read_data_i       (ram_rdata),
        .sample_data_o         (rd_if.sample_data),
        .sample_channel_o      (rd_if.sample_channel),
        .sample_last_o         (rd_if.sample_last),
        .sample_valid_o        (rd_if.sample_valid),
        .sample_ready_i        (rd_if.sample_ready),
        .overrun_o             (overrun),
        .debug_state_o         (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel buffer: one 32-bit word per frame/slot, slot bit 0 is the word MSB.
    logic [31:0] word_mem [NF][8];
    always @(posedge clk) ram_rdata <= word_mem[ram_addr[AW-1:8]][ram_addr[7:5]][5'd31 - ram_addr[4:0]];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: which frames get read, in what order, and how many overruns occur.
    int model_next = 0;
    bit synced = 0;
    int ovr_exp = 0;
    int ovr_seen = 0;

    task automatic set_lg(input int v);
        int lg_i;
        lg_i = v % NF;
        lg = lg_i[CB-1:0];
        if (!synced) begin
            synced = 1;
            model_next = lg_i;
        end
        while (model_next != (lg_i + 1) % NF) begin
            if (((lg_i - model_next) % NF + NF) % NF >= NF - 2) begin
                ovr_exp++;
                model_next = lg_i;
            end
            for (int c = 0; c < 8; c++)
                exp_q.push_back({CB'(model_next), 3'(c), word_mem[model_next][c][SLOT_BITS-1 -: SB]});
            model_next = (model_next + 1) % NF;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_data"}, rd_if.sample_data, 0);
        check({tag, "_chan"}, rd_if.sample_channel, 0);
        check({tag, "_last"}, rd_if.sample_last, 0);
        check({tag, "_valid"}, rd_if.sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_state"}, dbg_state, SYNC);
    endtask

    // ---------------- ready driver (random, with optional 50-cycle stall on channel 3) ----------------
    bit stall_armed = 0;
    int stall_cnt = 0;
    initial begin
        rd_if.sample_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_armed && rd_if.sample_valid && rd_if.sample_channel == 3'd3 && stall_cnt < 50) begin
                rd_if.sample_ready = 1'b0;
                stall_cnt++;
            end else begin
                if (stall_cnt >= 50) stall_armed = 0;
                rd_if.sample_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- monitor ----------------
    int exp_bit = 0;
    int first_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    logic [SB-1:0] prev_data;
    logic [2:0] prev_chan;
    logic prev_last;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset) begin
            exp_bit    = 0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (overrun) ovr_seen++;
            if (ram_addr != '0) begin
                check("read_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    if (exp_bit == 0 && e[EW-1 -: CB] == '0 && e[SB+2 -: 3] == 3'd0) begin
                        exp_bit   = 1;
                        first_cyc = cyc - 1;
                    end else if (exp_bit == 0) begin
                        first_cyc = cyc;
                    end
                    check("read_frame", ram_addr[AW-1:8], e[EW-1 -: CB]);
                    check("read_chan", ram_addr[7:5], e[SB+2 -: 3]);
                    check("read_bit", ram_addr[4:0], exp_bit);
                    exp_bit++;
                end
            end
            if (rd_if.sample_valid) check("addr_idle_in_hold", ram_addr, 0);
            if (rd_if.sample_valid && !prev_valid) begin
                check("bits_addressed", exp_bit, SB);
                check("valid_latency", cyc - first_cyc, SB + 1);
            end
            if (prev_stall) begin
                check("stall_valid", rd_if.sample_valid, 1);
                check("stall_data", rd_if.sample_data, prev_data);
                check("stall_chan", rd_if.sample_channel, prev_chan);
                check("stall_last", rd_if.sample_last, prev_last);
            end
            prev_stall = rd_if.sample_valid && !rd_if.sample_ready;
            prev_data  = rd_if.sample_data;
            prev_chan  = rd_if.sample_channel;
            prev_last  = rd_if.sample_last;
            if (rd_if.sample_valid && rd_if.sample_ready) begin
                check("sample_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sample_data", rd_if.sample_data, e[SB-1:0]);
                    check("sample_chan", rd_if.sample_channel, e[SB+2 -: 3]);
                    check("sample_last", rd_if.sample_last, e[SB+2 -: 3] == 3'd7);
                end
                exp_bit = 0;
            end
            prev_valid = rd_if.sample_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit found;
        reset = 1'b1;
        lg = CB'(1);
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 8; c++)
                word_mem[f][c] = (f == 2) ? 32'hA5A5A500 + 32'(c) : $urandom;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Known pattern: last_good 1 -> 2 reads frame 2.
        set_lg(2);
        drain();

        // Backpressure on channel 3 for 50 cycles.
        stall_armed = 1;
        set_lg(3);
        drain();
        check("stall_cycles", stall_cnt, 50);

        // Step through the top of the buffer and wrap to frame 0.
        for (int v = 4; v < NF; v++) begin
            set_lg(v);
            drain();
        end
        set_lg(0);
        drain();

        // Reader at frame 1, writer jumps to 7: lapped, skip to 7.
        set_lg(7);
        drain();
        check("overrun_jump", ovr_seen, ovr_exp);
        check("overrun_once", ovr_seen, 1);

        // Random frame contents and writer steps, including occasional laps.
        repeat (6) begin
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < 8; c++)
                    word_mem[f][c] = $urandom;
            set_lg(int'(lg) + $urandom_range(1, 7));
            drain();
        end
        check("overrun_random", ovr_seen, ovr_exp);

        // Reset in the middle of channel 5, bit 10.
        set_lg(int'(lg) + 1);
        n = 0;
        found = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (ram_addr != '0 && ram_addr[7:5] == 3'd5 && ram_addr[4:0] == 5'd10) found = 1;
        end
        check("reset_point_found", found, 1);
        #2 reset = 1'b1;
        exp_q.delete();
        synced = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("sync_waits", dbg_state, SYNC);
        set_lg(int'(lg) + 1);
        drain();
        check("overrun_final", ovr_seen, ovr_exp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/adat_frame_reader.md
ADAT_FRAME_READER -- requirements
Module: adat_frame_reader

Interface
REQ-001 SHALL have parameter CIRC_BUF_BITS, default 3, giving log2 of the number of 256-bit frames in the channel buffer.
REQ-002 SHALL have parameter SAMPLE_BITS, default 24, giving the number of MSB-aligned bits extracted per 32-bit slot.
REQ-003 SHALL have port clk_x4_i, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port last_good_frame_idx_i, input, CIRC_BUF_BITS bits: index of the newest fully written frame.
REQ-006 SHALL have port ram_read_addr_o, output, CIRC_BUF_BITS+8 bits: channel buffer read address, ordered {frame, channel[2:0], bit[4:0]}.
REQ-007 SHALL have port ram_read_data_i, input, 1 bit: buffer read data, valid one cycle after its address.
REQ-008 SHALL have port sample_data_o, output, SAMPLE_BITS bits: assembled sample.
REQ-009 SHALL have port sample_channel_o, output, 3 bits: ADAT channel of the sample, 0..7.
REQ-010 SHALL have port sample_last_o, output, 1 bit: high with channel 7.
REQ-011 SHALL have port sample_valid_o, output, 1 bit: sample handshake valid.
REQ-012 SHALL have port sample_ready_i, input, 1 bit: sample handshake ready.
REQ-013 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when unread frames are dropped.

Function
REQ-014 SHALL run an FSM with states SYNC, IDLE, READ, HOLD.
REQ-015 SYNC: capture last_good_frame_idx_i, then wait for it to change; on change, set rd_idx to the new value and go to IDLE.
REQ-016 IDLE: when rd_idx != last_good_frame_idx_i+1 (mod 2^CIRC_BUF_BITS), go to READ with ch=0.
REQ-017 READ: issue addresses {rd_idx, ch, b} for b=0..SAMPLE_BITS-1 on consecutive cycles; bit 0 is the MSB.
REQ-018 READ: shift each returned bit into the sample LSB on the cycle after its address.
REQ-019 READ: slot bits SAMPLE_BITS..31 SHALL never be addressed.
REQ-020 SHALL assert sample_valid_o the cycle after the last bit is captured, giving SAMPLE_BITS+1 cycles from the first address to valid, then enter HOLD.
REQ-021 HOLD: sample_data_o, sample_channel_o and sample_last_o SHALL stay stable while sample_valid_o=1 and sample_ready_i=0.
REQ-022 HOLD: on sample_valid_o&&sample_ready_i, deassert valid next cycle.
REQ-023 HOLD: after the accepted transfer, go to READ with ch+1 if ch<7.
REQ-024 HOLD: if ch=7, increment rd_idx (wrap 2^CIRC_BUF_BITS-1 -> 0) and go to IDLE.
REQ-025 Overrun: if (last_good - rd_idx) mod 2^CIRC_BUF_BITS >= 2^CIRC_BUF_BITS-2 on IDLE entry, set rd_idx=last_good_frame_idx_i and pulse overrun_o for one cycle.
REQ-026 An overrun detected while in READ/HOLD SHALL be acted on at the next IDLE entry; the current frame completes.
REQ-027 ram_read_addr_o SHALL be 0 outside READ.

Reset
REQ-028 On reset_i: state=SYNC, rd_idx=0, ch=0, ram_read_addr_o=0, sample_data_o=0, sample_channel_o=0, sample_last_o=0, sample_valid_o=0, overrun_o=0.
REQ-029 Reset asserted mid-READ/HOLD SHALL drop the partial sample with no valid emitted; SYNC is re-entered after release.

Structure
REQ-030 Package adat_pkg SHALL hold ADAT_CHANNELS=8, SLOT_BITS=32, FRAME_BITS=256 and the FSM state enum.
REQ-031 Sub-module serial_sample_shifter (MSB-first 1-bit to SAMPLE_BITS deserialiser with load-clear) SHALL hold the shift path.

Verification
REQ-032 Buffer frame 2 slot c = 0xA5A5A5_00 + c; last_good steps 1->2 -> eight samples 0xA5A5A5 with channel 0..7, last=1 on channel 7.
REQ-033 sample_ready_i held 0 for 50 cycles on channel 3 -> data/channel stable, no address activity, then channel 4 follows.
REQ-034 last_good 7 then 0 -> frame 7 then frame 0 read; addresses wrap to 0x000..0x0F7 region.
REQ-035 rd_idx=1, last_good jumps to 7 -> one overrun_o pulse; next frame read is 7.
REQ-036 reset_i pulsed at bit 10 of channel 5 -> no valid emitted; outputs 0; SYNC waits for the next last_good change.
